snitch_sb_ipool: RTL and testbench
==================================

SNITCH_SB_IPOOL -- requirements
Module: snitch_sb_ipool

Interface
REQ-001 SHALL have parameter Depth, default 8, meaning the number of pool indices (legal range 2..256).
REQ-002 SHALL derive local constant IdxWidth = $clog2(Depth), the width of one index.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port data_i, input, IdxWidth bits: the index being returned to the pool.
REQ-006 SHALL have port push_i, input, 1 bit: returns data_i to the pool this cycle.
REQ-007 SHALL have port data_o, output, IdxWidth bits: the next free index (head of the pool).
REQ-008 SHALL have port pop_i, input, 1 bit: takes the data_o index out of the pool this cycle.
REQ-009 SHALL have port full_o, output, 1 bit: all Depth indices are free.
REQ-010 SHALL have port empty_o, output, 1 bit: no free index is left.
REQ-011 SHALL have port usage_o, output, IdxWidth+1 bits: the number of free indices, 0..Depth.

Function
REQ-012 SHALL hold free indices in FIFO order, with pop taking from the head and push appending at the tail; storage is a circular buffer with head/tail pointers wrapping at Depth, not at 2^IdxWidth.
REQ-013 SHALL drive data_o combinationally from the head entry, with zero latency; data_o is valid whenever empty_o=0.
REQ-014 SHALL, when pop_i=1 and empty_o=0, advance the head at the clock edge, so the next entry appears on data_o in the following cycle.
REQ-015 SHALL, when push_i=1 and full_o=0, write data_i at the tail at the clock edge.
REQ-016 SHALL, on simultaneous legal push and pop, perform both; usage_o is unchanged.
REQ-017 SHALL ignore pop_i while empty_o=1 (no fall-through); a simultaneous push is still accepted.
REQ-018 SHALL ignore push_i while full_o=1; a simultaneous pop is still performed.
REQ-019 SHALL derive full_o = (usage_o == Depth) and empty_o = (usage_o == 0), both combinationally from registered state.
REQ-020 SHALL not check index uniqueness functionally; duplicate returns are stored as given.

Reset
REQ-021 SHALL, while rst_ni=0 at a clock edge, load entries 0..Depth-1 with index values 0..Depth-1 in order, set head to 0, tail to 0 and usage to Depth.
REQ-022 SHALL present these output values after reset: data_o=0, usage_o=Depth, full_o=1, empty_o=0.
REQ-023 SHALL let reset override any push or pop presented in the same cycle, including a reset asserted mid-operation.

Configuration
REQ-024 SHALL, when macro SNITCH_SB_IPOOL_ASSERT_EN is defined, add simulation-only checks that report an error for: push while full, pop while empty, an out-of-range data_i (>= Depth), and a push of an index already free (tracked with a Depth-bit free mask).
REQ-025 SHALL, when SNITCH_SB_IPOOL_ASSERT_EN is undefined, contain none of that checking logic, with functional behaviour identical to the defined case.

Structure
REQ-026 SHALL need no shared package types; index and count types are local and derived from Depth.
REQ-027 SHALL be a single module with no sub-module; the register macros are taken from the common registers header.

Verification (Depth=4)
REQ-028 SHALL cover reset then four pops: data_o sequence 0,1,2,3; usage_o goes 4,3,2,1,0; empty_o=1 at the end, full_o=0.
REQ-029 SHALL cover drain the pool, then push 2, then push 0: data_o=2, then after a pop data_o=0; usage_o goes 1,2,1.
REQ-030 SHALL cover simultaneous push(3)+pop with usage_o=2: usage_o stays 2, head advances, and 3 is placed at the tail.
REQ-031 SHALL cover pop while empty: no change to state, usage_o=0; push while full: ignored, usage_o=4.
REQ-032 SHALL cover reset asserted after two pops and one push: the next cycle shows data_o=0, usage_o=4, full_o=1.
REQ-033 SHALL cover, with SNITCH_SB_IPOOL_ASSERT_EN defined, a push of 1 right after reset: a duplicate error is reported and usage_o stays 4.

Source files
------------

// File: rtl/snitch_sb_ipool.sv
// Free-index pool: a circular FIFO of indices, reset-filled with 0..Depth-1.
// Define SNITCH_SB_IPOOL_ASSERT_EN to add simulation-only misuse checks.
module snitch_sb_ipool #(
   parameter int unsigned Depth = 8,
   localparam int unsigned IdxWidth = $clog2(Depth)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [IdxWidth-1:0] data_i,
   input  logic                push_i,
   output logic [IdxWidth-1:0] data_o,
   input  logic                pop_i,
   output logic                full_o,
   output logic                empty_o,
   output logic [IdxWidth:0]   usage_o
);

   localparam int unsigned CntWidth = IdxWidth + 1;

   logic [IdxWidth-1:0] mem_q [Depth];
   logic [IdxWidth-1:0] mem_d [Depth];
   logic [IdxWidth-1:0] head_q, head_d;
   logic [IdxWidth-1:0] tail_q, tail_d;
   logic [CntWidth-1:0] usage_q, usage_d;
   logic                push_ok, pop_ok;

   // Pointers wrap at Depth so non-power-of-two pools stay contiguous.
   function automatic logic [IdxWidth-1:0] next_ptr(input logic [IdxWidth-1:0] p);
      return (p == IdxWidth'(Depth - 1)) ? '0 : p + IdxWidth'(1);
   endfunction

   assign full_o  = (usage_q == CntWidth'(Depth));
   assign empty_o = (usage_q == '0);
   assign usage_o = usage_q;
   assign data_o  = mem_q[head_q];

   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      usage_d = usage_q;
      if (pop_ok) head_d = next_ptr(head_q);
      if (push_ok) begin
         mem_d[tail_q] = data_i;
         tail_d        = next_ptr(tail_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   usage_d = usage_q + CntWidth'(1);
         2'b01:   usage_d = usage_q - CntWidth'(1);
         default: usage_d = usage_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= IdxWidth'(i);
         head_q  <= '0;
         tail_q  <= '0;
         usage_q <= CntWidth'(Depth);
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         usage_q <= usage_d;
      end
   end

`ifdef SNITCH_SB_IPOOL_ASSERT_EN
   logic [Depth-1:0] free_mask_q;

   always @(posedge clk_i) begin
      if (!rst_ni) begin
         free_mask_q <= '1;
      end else begin
         if (push_i && full_o) $error("snitch_sb_ipool: push while full");
         if (pop_i && empty_o) $error("snitch_sb_ipool: pop while empty");
         if (push_i && ({1'b0, data_i} >= CntWidth'(Depth)))
            $error("snitch_sb_ipool: data_i %0d out of range", data_i);
         else if (push_i && free_mask_q[data_i])
            $error("snitch_sb_ipool: index %0d returned while already free", data_i);
         if (pop_ok) free_mask_q[data_o] <= 1'b0;
         if (push_ok && ({1'b0, data_i} < CntWidth'(Depth))) free_mask_q[data_i] <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_snitch_sb_ipool.sv
// Scoreboard bench for snitch_sb_ipool (Depth=4): a queue-based pool model
// predicts outputs per cycle; a separate monitor compares after each edge.
module tb_snitch_sb_ipool;

   localparam int D = 4;
   localparam int W = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         push = 1'b0;
   logic         pop = 1'b0;
   logic [W-1:0] din = '0;
   logic [W-1:0] dout;
   logic         full, empty;
   logic [W:0]   usage;

   typedef struct {
      int data;
      int usage;
      bit full;
      bit empty;
      string tag;
   } exp_t;

   exp_t expq[$];
   int   pool[$];
   int   total = 0;
   int   bad = 0;

   snitch_sb_ipool #(.Depth(D)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .data_i (din),
      .push_i (push),
      .data_o (dout),
      .pop_i  (pop),
      .full_o (full),
      .empty_o(empty),
      .usage_o(usage)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // One cycle of stimulus; the model is a plain list of free indices.
   task automatic step(input bit r, input bit ps, input int d, input bit pp, input string tag);
      exp_t e;
      bit   can_pop;
      bit   can_push;
      @(negedge clk);
      rst_n = ~r;
      push  = ps;
      din   = W'(d);
      pop   = pp;
      if (r) begin
         pool.delete();
         for (int i = 0; i < D; i++) pool.push_back(i);
      end else begin
         can_pop  = pool.size() > 0;
         can_push = pool.size() < D;
         if (pp && can_pop) void'(pool.pop_front());
         if (ps && can_push) pool.push_back(d);
      end
      e.usage = pool.size();
      e.full  = (pool.size() == D);
      e.empty = (pool.size() == 0);
      e.data  = e.empty ? -1 : pool[0];
      e.tag   = tag;
      expq.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check({e.tag, ".usage"}, int'(usage), e.usage);
            check({e.tag, ".full"}, int'(full), int'(e.full));
            check({e.tag, ".empty"}, int'(empty), int'(e.empty));
            if (!e.empty) check({e.tag, ".data"}, int'(dout), e.data);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : driver
      bit r, ps, pp;
      int d;
      // reset then drain: 0,1,2,3 and usage 4..0, then pop while empty
      step(1, 0, 0, 0, "reset");
      step(1, 1, 3, 1, "reset_ovr");
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, "drain");
      step(0, 0, 0, 1, "pop_empty");
      // push 2, push 0, pop
      step(0, 1, 2, 0, "push2");
      step(0, 1, 0, 0, "push0");
      step(0, 0, 0, 1, "pop_after");
      // usage 2 then simultaneous push(3)+pop
      step(0, 1, 1, 0, "fill");
      step(0, 1, 3, 1, "push_pop");
      step(0, 0, 0, 1, "pop_pp");
      step(0, 0, 0, 1, "pop_pp");
      // push+pop while empty: push accepted
      step(0, 1, 1, 1, "pp_empty");
      // fill up, then push while full, then push+pop while full
      step(0, 1, 2, 0, "fill");
      step(0, 1, 3, 0, "fill");
      step(0, 1, 0, 0, "fill");
      step(0, 1, 1, 0, "push_full");
      step(0, 1, 2, 1, "pp_full");
      // reset mid-operation
      step(1, 0, 0, 0, "reset");
      step(0, 0, 0, 1, "mid");
      step(0, 0, 0, 1, "mid");
      step(0, 1, 0, 0, "mid");
      step(1, 1, 1, 1, "reset_mid");
      step(0, 0, 0, 0, "idle");
      // randomized traffic with occasional resets and duplicate returns
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom_range(0, 59) == 0);
         ps = $urandom_range(0, 1);
         pp = $urandom_range(0, 1);
         d  = $urandom_range(0, D - 1);
         step(r, ps, d, pp, "rand");
      end
      @(negedge clk);
      rst_n = 1'b1;
      push  = 1'b0;
      pop   = 1'b0;
      repeat (3) @(negedge clk);
      check("scoreboard_drained", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
